// File: rtl/user_proj_timer_pkg.sv
// user_proj_timer_pkg: shared mode encoding and register map for the multi-channel timer
package user_proj_timer_pkg;
  typedef enum logic [1:0] {MODE_ONESHOT, MODE_PERIODIC, MODE_PWM, MODE_CAPTURE} mode_e;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_LOAD = 2'd1;
  localparam logic [1:0] REG_CMP  = 2'd2;
  localparam logic [1:0] REG_CNT  = 2'd3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_FLAG   = 4;
endpackage

// File: rtl/user_proj_timer_ch.sv
// user_proj_timer_ch: one timer channel with its registers, down-counter, capture synchroniser and pin logic
module user_proj_timer_ch
  import user_proj_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_we,
  input  logic [1:0]       i_reg,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_in,
  output logic [4:0]       o_ctrl,
  output logic [WIDTH-1:0] o_load,
  output logic [WIDTH-1:0] o_cmp,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_out,
  output logic             o_oeb,
  output logic             o_irq_req
);
  mode_e            r_mode;
  logic             r_en, r_irq_en, r_flag, r_out, r_edge;
  logic [2:0]       r_sync;
  logic [WIDTH-1:0] r_load, r_cmp, r_cnt;
  logic             w_expire, w_cap, w_wr_ctrl, w_clr;
  assign w_expire  = i_tick & r_en & (r_cnt == '0);
  assign w_cap     = r_edge & r_en & (r_mode == MODE_CAPTURE);
  assign w_wr_ctrl = i_we & (i_reg == REG_CTRL);
  assign w_clr     = i_we & (i_reg == REG_CNT) & i_wdata[0];
  // Later assignments win: register writes override counter updates, capture overrides a CMP write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode   <= MODE_ONESHOT;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_flag   <= 1'b0;
      r_out    <= 1'b0;
      r_edge   <= 1'b0;
      r_sync   <= '0;
      r_load   <= '0;
      r_cmp    <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_in};
      r_edge <= r_sync[1] & ~r_sync[2];
      r_flag <= w_expire | w_cap | (r_flag & ~w_clr);
      if (i_tick && r_en)
        r_cnt <= (r_cnt != '0) ? r_cnt - 1'b1 : (r_mode == MODE_ONESHOT) ? r_cnt : r_load;
      if (w_expire && r_mode == MODE_ONESHOT) r_en <= 1'b0;
      if (r_mode == MODE_PWM) r_out <= r_en & (r_cnt < r_cmp);
      else if (r_mode == MODE_CAPTURE) r_out <= 1'b0;
      else if (w_expire) r_out <= ~r_out;
      if (w_wr_ctrl) begin
        r_en     <= i_wdata[CTRL_EN];
        r_mode   <= mode_e'(i_wdata[CTRL_MODE +: 2]);
        r_irq_en <= i_wdata[CTRL_IRQ_EN];
        if (i_wdata[CTRL_EN] && !r_en) r_cnt <= r_load;
        if (!i_wdata[CTRL_EN]) r_out <= 1'b0;
      end
      if (i_we && i_reg == REG_LOAD) r_load <= i_wdata;
      if (i_we && i_reg == REG_CMP) r_cmp <= i_wdata;
      if (w_cap) r_cmp <= r_cnt;
    end
  end
  assign o_ctrl    = {r_flag, r_irq_en, r_mode, r_en};
  assign o_load    = r_load;
  assign o_cmp     = r_cmp;
  assign o_cnt     = r_cnt;
  assign o_out     = r_out;
  assign o_oeb     = ~r_en | (r_mode == MODE_CAPTURE);
  assign o_irq_req = r_flag & r_irq_en;
endmodule

// File: rtl/user_proj_timer_mc.sv
// user_proj_timer_mc: CHANNELS timers sharing one prescaler, with register decode, read mux and irq
module user_proj_timer_mc
  import user_proj_timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         cfg_we,
  input  logic                         cfg_re,
  input  logic [$clog2(CHANNELS)+1:0]  cfg_addr,
  input  logic [WIDTH-1:0]             cfg_wdata,
  output logic [WIDTH-1:0]             cfg_rdata,
  output logic                         cfg_rvalid,
  input  logic [CHANNELS-1:0]          ch_in,
  output logic [CHANNELS-1:0]          ch_out,
  output logic [CHANNELS-1:0]          ch_oeb,
  output logic                         irq
);
  localparam int AW = $clog2(CHANNELS) + 2;
  logic [15:0]                    r_pre;
  logic [WIDTH-1:0]               r_rdata, w_rd;
  logic                           r_rvalid, r_irq, w_tick;
  logic [AW-1:0]                  w_ch;
  logic [CHANNELS-1:0][4:0]       w_ctrl;
  logic [CHANNELS-1:0][WIDTH-1:0] w_load, w_cmp, w_cnt;
  logic [CHANNELS-1:0]            w_irq_req;
  assign w_tick = r_pre == 16'(PRESCALE - 1);
  assign w_ch   = cfg_addr >> 2;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    user_proj_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .i_clk     (wb_clk_i),
      .i_rst_n   (wb_rst_ni),
      .i_tick    (w_tick),
      .i_we      (cfg_we && w_ch == AW'(i)),
      .i_reg     (cfg_addr[1:0]),
      .i_wdata   (cfg_wdata),
      .i_in      (ch_in[i]),
      .o_ctrl    (w_ctrl[i]),
      .o_load    (w_load[i]),
      .o_cmp     (w_cmp[i]),
      .o_cnt     (w_cnt[i]),
      .o_out     (ch_out[i]),
      .o_oeb     (ch_oeb[i]),
      .o_irq_req (w_irq_req[i])
    );
  end
  // Channel numbers with no matching instance fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (w_ch == AW'(k))
        w_rd = (cfg_addr[1:0] == REG_CTRL) ? WIDTH'(w_ctrl[k]) :
               (cfg_addr[1:0] == REG_LOAD) ? w_load[k] :
               (cfg_addr[1:0] == REG_CMP)  ? w_cmp[k]  : w_cnt[k];
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_pre    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_pre    <= w_tick ? '0 : r_pre + 1'b1;
      r_rvalid <= cfg_re;
      r_irq    <= |w_irq_req;
      if (cfg_re) r_rdata <= w_rd;
    end
  end
  assign cfg_rdata  = r_rdata;
  assign cfg_rvalid = r_rvalid;
  assign irq        = r_irq;
endmodule

// File: tb/tb_user_proj_timer_mc.sv
// tb_user_proj_timer_mc: directed bench for user_proj_timer_mc, PRESCALE=1 (dut0) and PRESCALE=4 (dut1)
module tb_user_proj_timer_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we [2], re [2], rvalid [2], irq [2];
  logic [3:0]  addr [2];
  logic [15:0] wdata [2], rdata [2];
  logic [3:0]  chin0, chout0, choeb0;
  logic [2:0]  chin1, chout1, choeb1;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  user_proj_timer_mc #(.CHANNELS(4), .WIDTH(16), .PRESCALE(1)) dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .cfg_we(we[0]), .cfg_re(re[0]), .cfg_addr(addr[0]),
    .cfg_wdata(wdata[0]), .cfg_rdata(rdata[0]), .cfg_rvalid(rvalid[0]),
    .ch_in(chin0), .ch_out(chout0), .ch_oeb(choeb0), .irq(irq[0]));

  user_proj_timer_mc #(.CHANNELS(3), .WIDTH(16), .PRESCALE(4)) dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .cfg_we(we[1]), .cfg_re(re[1]), .cfg_addr(addr[1]),
    .cfg_wdata(wdata[1]), .cfg_rdata(rdata[1]), .cfg_rvalid(rvalid[1]),
    .ch_in(chin1), .ch_out(chout1), .ch_oeb(choeb1), .irq(irq[1]));

  // Both tasks start at a falling edge and return at the falling edge after the rising edge used.
  task automatic wr(input int s, input logic [3:0] a, input logic [15:0] v);
    we[s] = 1'b1; addr[s] = a; wdata[s] = v;
    @(negedge clk);
    we[s] = 1'b0;
  endtask

  task automatic rd(input int s, input logic [3:0] a, output logic [15:0] v);
    re[s] = 1'b1; addr[s] = a;
    @(negedge clk);
    re[s] = 1'b0;
    v = rdata[s];
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if ({chout0, irq[0], rvalid[0]} !== 6'b0 || rdata[0] !== 16'h0) begin
      n_fail++; $display("FAIL reset_outs got out=%b irq=%b rv=%b rd=%h exp 0", chout0, irq[0], rvalid[0], rdata[0]); end
    n_tests++; if (choeb0 !== 4'hf || choeb1 !== 3'h7) begin
      n_fail++; $display("FAIL reset_oeb got %b/%b exp 1111/111", choeb0, choeb1); end
    rst_n = 1'b1;
    rd(0, 4'd1, d);
    n_tests++; if (d !== 16'h0 || rvalid[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_load got %h rv=%b exp 0 rv=1", d, rvalid[0]); end
    @(negedge clk);
    n_tests++; if (rvalid[0] !== 1'b0) begin
      n_fail++; $display("FAIL rvalid_pulse got %b exp 0", rvalid[0]); end
  endtask

  task automatic test_periodic();
    logic [15:0] d;
    logic e;
    wr(0, 4'd1, 16'd3);
    wr(0, 4'd0, 16'h3);
    n_tests++; if (choeb0[0] !== 1'b0) begin
      n_fail++; $display("FAIL periodic_oeb got %b exp 0", choeb0[0]); end
    for (int k = 0; k < 12; k++) begin
      e = ((k / 4) % 2) == 1;
      n_tests++; if (chout0[0] !== e) begin
        n_fail++; $display("FAIL periodic_out k=%0d got %b exp %b", k, chout0[0], e); end
      @(negedge clk);
    end
    n_tests++; if (irq[0] !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked got %b exp 0", irq[0]); end
    wr(0, 4'd0, 16'hB);
    n_tests++; if (irq[0] !== 1'b0) begin
      n_fail++; $display("FAIL irq_latency got %b exp 0", irq[0]); end
    @(negedge clk);
    n_tests++; if (irq[0] !== 1'b1) begin
      n_fail++; $display("FAIL irq_high got %b exp 1", irq[0]); end
    rd(0, 4'd0, d);
    n_tests++; if (d !== 16'h1B) begin
      n_fail++; $display("FAIL periodic_ctrl got %h exp 1b", d); end
    @(negedge clk);
    wr(0, 4'd3, 16'd1);
    rd(0, 4'd0, d);
    n_tests++; if (d !== 16'h0B) begin
      n_fail++; $display("FAIL flag_clear got %h exp 0b", d); end
    n_tests++; if (irq[0] !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear got %b exp 0", irq[0]); end
    we[0] = 1'b1; re[0] = 1'b1; addr[0] = 4'd1; wdata[0] = 16'd7;
    @(negedge clk);
    we[0] = 1'b0; re[0] = 1'b0;
    n_tests++; if (rdata[0] !== 16'd3) begin
      n_fail++; $display("FAIL rw_same_cycle got %h exp 3", rdata[0]); end
    rd(0, 4'd1, d);
    n_tests++; if (d !== 16'd7) begin
      n_fail++; $display("FAIL rw_written got %h exp 7", d); end
    wr(0, 4'd0, 16'h0);
    n_tests++; if (chout0[0] !== 1'b0 || choeb0[0] !== 1'b1) begin
      n_fail++; $display("FAIL disable got out=%b oeb=%b exp 0/1", chout0[0], choeb0[0]); end
    wr(0, 4'd3, 16'd1);
  endtask

  task automatic test_oneshot();
    logic [15:0] d;
    wr(0, 4'd5, 16'd5);
    wr(0, 4'd4, 16'h1);
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (chout0[1] !== (k >= 6)) begin
        n_fail++; $display("FAIL oneshot_out k=%0d got %b exp %b", k, chout0[1], k >= 6); end
      @(negedge clk);
    end
    rd(0, 4'd4, d);
    n_tests++; if (d !== 16'h10) begin
      n_fail++; $display("FAIL oneshot_ctrl got %h exp 10", d); end
    rd(0, 4'd7, d);
    n_tests++; if (d !== 16'h0 || choeb0[1] !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_cnt got %h oeb=%b exp 0/1", d, choeb0[1]); end
    wr(0, 4'd4, 16'h0);
    wr(0, 4'd7, 16'd1);
  endtask

  task automatic test_pwm();
    logic e;
    wr(0, 4'd9, 16'd9);
    wr(0, 4'd10, 16'd3);
    wr(0, 4'd8, 16'h5);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = ((k - 1) % 10) >= 7;
      n_tests++; if (chout0[2] !== e) begin
        n_fail++; $display("FAIL pwm_duty k=%0d got %b exp %b", k, chout0[2], e); end
    end
    wr(0, 4'd10, 16'd0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (chout0[2] !== 1'b0) begin
        n_fail++; $display("FAIL pwm_cmp0 k=%0d got %b exp 0", k, chout0[2]); end
      @(negedge clk);
    end
    wr(0, 4'd10, 16'd12);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (chout0[2] !== 1'b1) begin
        n_fail++; $display("FAIL pwm_cmp12 k=%0d got %b exp 1", k, chout0[2]); end
      @(negedge clk);
    end
    wr(0, 4'd8, 16'h0);
  endtask

  task automatic test_capture();
    logic [15:0] d;
    wr(0, 4'd13, 16'd100);
    wr(0, 4'd12, 16'h7);
    repeat (40) @(negedge clk);
    chin0[3] = 1'b1;
    repeat (4) @(negedge clk);
    chin0[3] = 1'b0;
    rd(0, 4'd14, d);
    n_tests++; if (d !== 16'd57) begin
      n_fail++; $display("FAIL capture_cmp got %0d exp 57", d); end
    rd(0, 4'd12, d);
    n_tests++; if (d !== 16'h17) begin
      n_fail++; $display("FAIL capture_ctrl got %h exp 17", d); end
    n_tests++; if (choeb0[3] !== 1'b1 || chout0[3] !== 1'b0) begin
      n_fail++; $display("FAIL capture_pins got oeb=%b out=%b exp 1/0", choeb0[3], chout0[3]); end
    wr(0, 4'd12, 16'h0);
  endtask

  task automatic test_midcount_reset();
    logic [15:0] d;
    wr(0, 4'd1, 16'd3);
    wr(0, 4'd0, 16'hB);
    repeat (5) @(negedge clk);
    n_tests++; if (chout0[0] !== 1'b1 || irq[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got out=%b irq=%b exp 1/1", chout0[0], irq[0]); end
    rd(0, 4'd1, d);
    n_tests++; if (d !== 16'd3 || rvalid[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_rd got %h rv=%b exp 3/1", d, rvalid[0]); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (chout0 !== 4'h0 || irq[0] !== 1'b0 || rvalid[0] !== 1'b0 || rdata[0] !== 16'h0) begin
      n_fail++; $display("FAIL async_reset got out=%b irq=%b rv=%b rd=%h exp 0", chout0, irq[0], rvalid[0], rdata[0]); end
    n_tests++; if (choeb0 !== 4'hf) begin
      n_fail++; $display("FAIL async_reset_oeb got %b exp 1111", choeb0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_prescale();
    logic [15:0] d;
    rst_n = 1'b1;
    wr(1, 4'd1, 16'd2);
    wr(1, 4'd9, 16'd5);
    wr(1, 4'd0, 16'h3);
    wr(1, 4'd8, 16'h3);
    rd(1, 4'd3, d);
    n_tests++; if (d !== 16'd1) begin
      n_fail++; $display("FAIL pre4_cnt0_a got %0d exp 1", d); end
    rd(1, 4'd11, d);
    n_tests++; if (d !== 16'd5) begin
      n_fail++; $display("FAIL pre4_cnt2_a got %0d exp 5", d); end
    @(negedge clk);
    rd(1, 4'd3, d);
    n_tests++; if (d !== 16'd1) begin
      n_fail++; $display("FAIL pre4_hold got %0d exp 1", d); end
    rd(1, 4'd11, d);
    n_tests++; if (d !== 16'd4) begin
      n_fail++; $display("FAIL pre4_cnt2_b got %0d exp 4", d); end
    rd(1, 4'd3, d);
    n_tests++; if (d !== 16'd0) begin
      n_fail++; $display("FAIL pre4_cnt0_b got %0d exp 0", d); end
    @(negedge clk);
    n_tests++; if (chout1[0] !== 1'b0) begin
      n_fail++; $display("FAIL pre4_out_before got %b exp 0", chout1[0]); end
    @(negedge clk);
    n_tests++; if (chout1[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre4_out_toggle got %b exp 1", chout1[0]); end
    repeat (11) @(negedge clk);
    wr(1, 4'd3, 16'd1);
    rd(1, 4'd0, d);
    n_tests++; if (d !== 16'h13) begin
      n_fail++; $display("FAIL set_beats_clear got %h exp 13", d); end
    n_tests++; if (chout1[0] !== 1'b0) begin
      n_fail++; $display("FAIL pre4_out_second got %b exp 0", chout1[0]); end
    rd(1, 4'd11, d);
    n_tests++; if (d !== 16'd0) begin
      n_fail++; $display("FAIL pre4_cnt2_c got %0d exp 0", d); end
    wr(1, 4'd13, 16'h55);
    rd(1, 4'd13, d);
    n_tests++; if (d !== 16'h0) begin
      n_fail++; $display("FAIL out_of_range got %h exp 0", d); end
  endtask

  task automatic test_after_reset();
    logic [15:0] d;
    rd(0, 4'd3, d);
    n_tests++; if (d !== 16'h0 || choeb0 !== 4'hf) begin
      n_fail++; $display("FAIL post_reset_cnt got %h oeb=%b exp 0/1111", d, choeb0); end
    rd(0, 4'd0, d);
    n_tests++; if (d !== 16'h0) begin
      n_fail++; $display("FAIL post_reset_ctrl got %h exp 0", d); end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      we[s] = 1'b0; re[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
    end
    chin0 = '0;
    chin1 = '0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_pwm();
    test_capture();
    test_midcount_reset();
    test_prescale();
    test_after_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
